// File: rtl/interrupt_request_controller.sv
`default_nettype none
// ============================================================================
// Module      : interrupt_request_controller
// Description : Synchronises external interrupt requests, latches edges or
//               tracks levels, applies the enable mask and presents INT0
//               (non-maskable) and INT1 (maskable, lowest index first) to the
//               interrupt state machine. Reports the source taken on each
//               accepted maskable acknowledge.
// Revision    : 1.0 - initial release
// ============================================================================
module interrupt_request_controller #(
    parameter int               NSRC        = 4,
    parameter int               SYNC_STAGES = 2,
    parameter logic [NSRC-1:0]  EDGE_MODE   = {NSRC{1'b1}}
) (
    input  logic                      CLK,
    input  logic                      RESET,
    input  logic                      COMMIT,
    input  logic                      NMI_IN,
    input  logic [NSRC-1:0]           IRQ_IN,
    input  logic                      ACK0,
    input  logic                      ACK1,
    input  logic                      MASK_WR,
    input  logic [NSRC-1:0]           MASK_DATA,
    input  logic [NSRC-1:0]           PEND_CLR,
    output logic                      INT0,
    output logic                      INT1,
    output logic [NSRC-1:0]           PENDING,
    output logic [NSRC-1:0]           MASK,
    output logic [$clog2(NSRC)-1:0]   CAUSE,
    output logic                      CAUSE_VALID
);

    localparam int CW = $clog2(NSRC);

    // Synchroniser chains and the delayed copy used for edge detection
    logic [NSRC-1:0]        irq_sync [SYNC_STAGES];
    logic [SYNC_STAGES-1:0] nmi_sync;
    logic [NSRC-1:0]        irq_prev;
    logic                   nmi_prev;

    logic [NSRC-1:0]        irq_q;
    logic                   nmi_q;
    logic [NSRC-1:0]        irq_rise;
    logic                   nmi_rise;

    // Pending state: edge-mode bits are latched, level-mode bits follow the line
    logic [NSRC-1:0]        edge_pend;
    logic                   nmi_pend;

    // Acknowledge selection
    logic [NSRC-1:0]        pend_masked;
    logic [CW-1:0]          sel;
    logic                   ack1_take;
    logic                   ack0_take;
    logic [NSRC-1:0]        ack_clr;

    assign irq_q    = irq_sync[SYNC_STAGES-1];
    assign nmi_q    = nmi_sync[SYNC_STAGES-1];
    assign irq_rise = irq_q & ~irq_prev;
    assign nmi_rise = nmi_q & ~nmi_prev;

    assign PENDING     = (edge_pend & EDGE_MODE) | (irq_q & ~EDGE_MODE);
    assign pend_masked = PENDING & MASK;
    assign INT0        = nmi_pend;
    assign INT1        = |pend_masked;

    assign ack1_take = COMMIT & ACK1 & (|pend_masked);
    assign ack0_take = COMMIT & ACK0;
    assign ack_clr   = ack1_take ? ({{(NSRC-1){1'b0}}, 1'b1} << sel) : '0;

    // Priority encoder: lowest enabled pending index wins
    always_comb begin
        sel = '0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (pend_masked[i]) begin
                sel = CW'(i);
            end
        end
    end

    // Input synchronisers and edge-detect history, free-running every cycle
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                irq_sync[k] <= '0;
            end
            nmi_sync <= '0;
            irq_prev <= '0;
            nmi_prev <= 1'b0;
        end else begin
            irq_sync[0] <= IRQ_IN;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                irq_sync[k] <= irq_sync[k-1];
            end
            nmi_sync <= {nmi_sync[SYNC_STAGES-2:0], NMI_IN};
            irq_prev <= irq_q;
            nmi_prev <= nmi_q;
        end
    end

    // Edge pending bits: a new rise always beats a software or ack clear
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            edge_pend <= '0;
        end else begin
            edge_pend <= ((edge_pend & ~(PEND_CLR | ack_clr)) | irq_rise) & EDGE_MODE;
        end
    end

    // Non-maskable pending flag: rise beats a committed ACK0
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            nmi_pend <= 1'b0;
        end else if (nmi_rise) begin
            nmi_pend <= 1'b1;
        end else if (ack0_take) begin
            nmi_pend <= 1'b0;
        end
    end

    // Enable mask register, written regardless of COMMIT
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            MASK <= '0;
        end else if (MASK_WR) begin
            MASK <= MASK_DATA;
        end
    end

    // Capture the serviced source on an accepted maskable acknowledge
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            CAUSE       <= '0;
            CAUSE_VALID <= 1'b0;
        end else if (ack1_take) begin
            CAUSE       <= sel;
            CAUSE_VALID <= 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_interrupt_request_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_interrupt_request_controller
// Description : Directed vector table plus hand sequences for NMI hold,
//               level-mode sources and asynchronous reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_interrupt_request_controller;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic       COMMIT = 1'b0;
    logic       NMI_IN = 1'b0;
    logic [3:0] IRQ_IN = 4'b0;
    logic       ACK0 = 1'b0;
    logic       ACK1 = 1'b0;
    logic       MASK_WR = 1'b0;
    logic [3:0] MASK_DATA = 4'b0;
    logic [3:0] PEND_CLR = 4'b0;

    logic       int0, int1, cause_valid;
    logic [3:0] pending, mask;
    logic [1:0] cause;

    logic       l_int0, l_int1, l_cause_valid;
    logic [3:0] l_pending, l_mask;
    logic [1:0] l_cause;

    int tests = 0;
    int fails = 0;

    always #5 CLK = ~CLK;

    interrupt_request_controller #(.NSRC(4), .SYNC_STAGES(2), .EDGE_MODE(4'b1111)) dut (
        .CLK(CLK), .RESET(RESET), .COMMIT(COMMIT), .NMI_IN(NMI_IN), .IRQ_IN(IRQ_IN),
        .ACK0(ACK0), .ACK1(ACK1), .MASK_WR(MASK_WR), .MASK_DATA(MASK_DATA),
        .PEND_CLR(PEND_CLR), .INT0(int0), .INT1(int1), .PENDING(pending),
        .MASK(mask), .CAUSE(cause), .CAUSE_VALID(cause_valid)
    );

    interrupt_request_controller #(.NSRC(4), .SYNC_STAGES(2), .EDGE_MODE(4'b1110)) dut_lvl (
        .CLK(CLK), .RESET(RESET), .COMMIT(COMMIT), .NMI_IN(NMI_IN), .IRQ_IN(IRQ_IN),
        .ACK0(ACK0), .ACK1(ACK1), .MASK_WR(MASK_WR), .MASK_DATA(MASK_DATA),
        .PEND_CLR(PEND_CLR), .INT0(l_int0), .INT1(l_int1), .PENDING(l_pending),
        .MASK(l_mask), .CAUSE(l_cause), .CAUSE_VALID(l_cause_valid)
    );

    typedef struct {
        logic       mwr;
        logic [3:0] mdata;
        logic [3:0] irq;
        logic       nmi;
        logic       commit;
        logic       ack0;
        logic       ack1;
        logic [3:0] pclr;
        logic       e_int0;
        logic       e_int1;
        logic [3:0] e_pend;
        logic [3:0] e_mask;
        logic [1:0] e_cause;
        logic       e_cv;
    } vec_t;

    localparam int NVEC = 19;
    vec_t vecs [NVEC];

    function automatic vec_t mk(input logic mwr, input logic [3:0] mdata,
                                input logic [3:0] irq, input logic nmi,
                                input logic commit, input logic ack0,
                                input logic ack1, input logic [3:0] pclr,
                                input logic e_int0, input logic e_int1,
                                input logic [3:0] e_pend, input logic [3:0] e_mask,
                                input logic [1:0] e_cause, input logic e_cv);
        vec_t v;
        v.mwr = mwr; v.mdata = mdata; v.irq = irq; v.nmi = nmi;
        v.commit = commit; v.ack0 = ack0; v.ack1 = ack1; v.pclr = pclr;
        v.e_int0 = e_int0; v.e_int1 = e_int1; v.e_pend = e_pend;
        v.e_mask = e_mask; v.e_cause = e_cause; v.e_cv = e_cv;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        COMMIT = 1'b0; ACK0 = 1'b0; ACK1 = 1'b0;
        MASK_WR = 1'b0; MASK_DATA = 4'b0; PEND_CLR = 4'b0;
    endtask

    initial begin
        //               mwr mdata    irq      nmi  com  a0   a1   pclr   | i0   i1   pend     mask     cause cv
        vecs[0]  = mk(1'b1, 4'b1011, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000, 4'b1011, 2'd0, 1'b0);
        vecs[1]  = mk(1'b0, 4'b0000, 4'b0100, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000, 4'b1011, 2'd0, 1'b0);
        vecs[2]  = mk(1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000, 4'b1011, 2'd0, 1'b0);
        vecs[3]  = mk(1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0100, 4'b1011, 2'd0, 1'b0);
        vecs[4]  = mk(1'b1, 4'b0100, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b1, 4'b0100, 4'b0100, 2'd0, 1'b0);
        vecs[5]  = mk(1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b1, 4'b0100, 4'b0100, 2'd0, 1'b0);
        vecs[6]  = mk(1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0100, 2'd2, 1'b1);
        vecs[7]  = mk(1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0100, 2'd2, 1'b1);
        vecs[8]  = mk(1'b1, 4'b1111, 4'b1010, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000, 4'b1111, 2'd2, 1'b1);
        vecs[9]  = mk(1'b0, 4'b0000, 4'b1010, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000, 4'b1111, 2'd2, 1'b1);
        vecs[10] = mk(1'b0, 4'b0000, 4'b1010, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b1, 4'b1010, 4'b1111, 2'd2, 1'b1);
        vecs[11] = mk(1'b0, 4'b0000, 4'b1010, 1'b0, 1'b1, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b1, 4'b1000, 4'b1111, 2'd1, 1'b1);
        vecs[12] = mk(1'b0, 4'b0000, 4'b1010, 1'b0, 1'b1, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b0, 4'b0000, 4'b1111, 2'd3, 1'b1);
        vecs[13] = mk(1'b0, 4'b0000, 4'b0001, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000, 4'b1111, 2'd3, 1'b1);
        vecs[14] = mk(1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000, 4'b1111, 2'd3, 1'b1);
        vecs[15] = mk(1'b0, 4'b0000, 4'b0001, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b1, 4'b0001, 4'b1111, 2'd3, 1'b1);
        vecs[16] = mk(1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b1, 4'b0001, 4'b1111, 2'd3, 1'b1);
        vecs[17] = mk(1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b1, 4'b0001, 1'b0, 1'b1, 4'b0001, 4'b1111, 2'd0, 1'b1);
        vecs[18] = mk(1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0001, 1'b0, 1'b0, 4'b0000, 4'b1111, 2'd0, 1'b1);

        // Reset state
        tick();
        tick();
        check("reset int0", int0, 0);
        check("reset int1", int1, 0);
        check("reset pending", pending, 0);
        check("reset mask", mask, 0);
        check("reset cause", cause, 0);
        check("reset cause_valid", cause_valid, 0);
        RESET = 1'b0;

        // Table: masking, priority acks, ignored acks, set-wins-over-clear
        for (int i = 0; i < NVEC; i++) begin
            MASK_WR = vecs[i].mwr; MASK_DATA = vecs[i].mdata; IRQ_IN = vecs[i].irq;
            NMI_IN = vecs[i].nmi; COMMIT = vecs[i].commit; ACK0 = vecs[i].ack0;
            ACK1 = vecs[i].ack1; PEND_CLR = vecs[i].pclr;
            tick();
            check($sformatf("row%0d int0", i), int0, vecs[i].e_int0);
            check($sformatf("row%0d int1", i), int1, vecs[i].e_int1);
            check($sformatf("row%0d pending", i), pending, vecs[i].e_pend);
            check($sformatf("row%0d mask", i), mask, vecs[i].e_mask);
            check($sformatf("row%0d cause", i), cause, vecs[i].e_cause);
            check($sformatf("row%0d cause_valid", i), cause_valid, vecs[i].e_cv);
        end
        idle_inputs();
        IRQ_IN = 4'b0;
        tick();

        // NMI held across uncommitted acks; ACK0 and ACK1 together on commit
        NMI_IN = 1'b1; IRQ_IN = 4'b0100;
        tick();
        check("nmi edge1 int0", int0, 0);
        NMI_IN = 1'b0; IRQ_IN = 4'b0000;
        tick();
        check("nmi edge2 int0", int0, 0);
        check("irq edge2 int1", int1, 0);
        tick();
        check("nmi edge3 int0", int0, 1);
        check("irq edge3 int1", int1, 1);
        check("irq edge3 pending", pending, 4'b0100);
        ACK0 = 1'b1; ACK1 = 1'b1; COMMIT = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick();
            check($sformatf("nmi hold%0d int0", c), int0, 1);
            check($sformatf("irq hold%0d int1", c), int1, 1);
        end
        COMMIT = 1'b1;
        tick();
        check("dual ack int0", int0, 0);
        check("dual ack int1", int1, 0);
        check("dual ack cause", cause, 2);
        check("dual ack pending", pending, 0);
        idle_inputs();
        tick();

        // Level-mode source 0 on the second instance
        IRQ_IN = 4'b0001;
        tick();
        check("lvl edge1 pend0", l_pending[0], 0);
        tick();
        check("lvl edge2 pend0", l_pending[0], 1);
        check("lvl edge2 int1", l_int1, 1);
        COMMIT = 1'b1; ACK1 = 1'b1; PEND_CLR = 4'b0001;
        tick();
        check("lvl ack cause", l_cause, 0);
        check("lvl ack cause_valid", l_cause_valid, 1);
        check("lvl ack pend0", l_pending[0], 1);
        idle_inputs();
        IRQ_IN = 4'b0000;
        tick();
        check("lvl drop1 pend0", l_pending[0], 1);
        tick();
        check("lvl drop2 pend0", l_pending[0], 0);

        // Asynchronous reset with everything pending, requests held through release
        IRQ_IN = 4'b1111; NMI_IN = 1'b1;
        tick();
        tick();
        tick();
        check("pre-reset pending", pending, 4'b1111);
        check("pre-reset int0", int0, 1);
        #2;
        RESET = 1'b1;
        #1;
        check("async reset int0", int0, 0);
        check("async reset int1", int1, 0);
        check("async reset pending", pending, 0);
        check("async reset mask", mask, 0);
        check("async reset cause", cause, 0);
        check("async reset cause_valid", cause_valid, 0);
        tick();
        RESET = 1'b0;
        tick();
        check("relatch edge1 pending", pending, 0);
        tick();
        check("relatch edge2 pending", pending, 0);
        check("relatch edge2 int0", int0, 0);
        tick();
        check("relatch edge3 pending", pending, 4'b1111);
        check("relatch edge3 int0", int0, 1);
        check("relatch edge3 int1", int1, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
